// File: rtl/chord_seq_if.sv
// chord_seq_if: control, slot-data and playback-status bundle between chord registers, sequencer and sound stage.
interface chord_seq_if #(
    parameter int NUM_SLOTS = 4,
    parameter int NOTE_W    = 10
);
    localparam int SW = $clog2(NUM_SLOTS);
    logic                        start;
    logic                        stop;
    logic                        loop_en;
    logic [SW-1:0]               num_steps;
    logic [NUM_SLOTS*NOTE_W-1:0] slot_notes;
    logic [SW-1:0]               slot_sel;
    logic [NOTE_W-1:0]           notes_out;
    logic                        playing;
    logic                        step_done;
    logic                        seq_done;
    modport master (
        output start, stop, loop_en, num_steps, slot_notes,
        input  slot_sel, notes_out, playing, step_done, seq_done
    );
    modport slave (
        input  start, stop, loop_en, num_steps, slot_notes,
        output slot_sel, notes_out, playing, step_done, seq_done
    );
endinterface

// File: rtl/chord_sequencer.sv
// chord_sequencer: steps through chord slots with a timed sound window and silent gap per step.
module chord_sequencer #(
    parameter int NUM_SLOTS      = 4,
    parameter int NOTE_W         = 10,
    parameter int TICKS_PER_STEP = 25000000,
    parameter int GAP_TICKS      = 2500000
) (
    input logic        CLOCK_50,
    input logic        reset,
    chord_seq_if.slave bus
);
    localparam int SW   = $clog2(NUM_SLOTS);
    localparam int CMAX = (TICKS_PER_STEP > GAP_TICKS) ? TICKS_PER_STEP : GAP_TICKS;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] T_LAST = CW'(TICKS_PER_STEP - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_TICKS - 1);
    typedef enum logic [1:0] {IDLE, SOUND, GAP} state_t;
    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d, len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          step_done_q, step_done_d, seq_done_q, seq_done_d, step_end;
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        step_done_d = 1'b0;
        seq_done_d  = 1'b0;
        step_end    = 1'b0;
        case (state_q)
            IDLE: if (bus.start && !bus.stop) begin
                len_d   = bus.num_steps;
                slot_d  = '0;
                cnt_d   = '0;
                state_d = SOUND;
            end
            SOUND: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == T_LAST) begin
                    cnt_d = '0;
                    if (GAP_TICKS > 0) state_d = GAP;
                    else step_end = 1'b1;
                end
            end
            GAP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == G_LAST) begin
                    cnt_d    = '0;
                    step_end = 1'b1;
                end
            end
            default: ;
        endcase
        if (step_end) begin
            step_done_d = 1'b1;
            state_d     = (slot_q < len_q || bus.loop_en) ? SOUND : IDLE;
            slot_d      = (slot_q < len_q) ? slot_q + 1'b1 : '0;
            seq_done_d  = !(slot_q < len_q) && !bus.loop_en;
        end
        // Abort overrides any step-end in progress and suppresses its pulses.
        if (state_q != IDLE && bus.stop) begin
            state_d     = IDLE;
            slot_d      = '0;
            cnt_d       = '0;
            step_done_d = 1'b0;
            seq_done_d  = 1'b0;
        end
    end
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            step_done_q <= 1'b0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            step_done_q <= step_done_d;
            seq_done_q  <= seq_done_d;
        end
    end
    assign bus.slot_sel  = slot_q;
    assign bus.notes_out = (state_q == SOUND) ? bus.slot_notes[slot_q*NOTE_W +: NOTE_W] : '0;
    assign bus.playing   = state_q != IDLE;
    assign bus.step_done = step_done_q;
    assign bus.seq_done  = seq_done_q;
endmodule

// File: doc/chord_sequencer.md
Name: chord_sequencer

Overview:
- Playback controller for the four-slot chord register bank.
- After a start pulse it steps through slots 0..N-1 at a fixed tempo. Each slot's 10-bit note vector is gated onto the note bus for a sound window, followed by a silent gap.
- It optionally loops, and signals per-step and end-of-sequence events.
- It sits between the chord registers and the note-producing (LED/audio) stage, replacing manual key-press playback.

Parameters:
- NUM_SLOTS, 4, number of chord slots; slot index width is 2.
- NOTE_W, 10, note vector width per slot.
- TICKS_PER_STEP, 25000000, sound-window length in clock cycles; 0.5 s at 50 MHz; must be >= 1.
- GAP_TICKS, 2500000, silent-gap length in cycles after each sound window; 0 means no gap.

Ports:
- CLOCK_50  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin sequence; level-sampled, acted on only in IDLE.
- stop  input  1  abort playback immediately.
- loop_en  input  1  when 1, restart from slot 0 after the last step.
- num_steps  input  2  sequence length minus 1 (0 = one step, 3 = four steps); latched on accepted start.
- slot_notes  input  NUM_SLOTS*NOTE_W  flattened chord-register outputs; slot k occupies bits [k*NOTE_W +: NOTE_W].
- slot_sel  output  2  index of the current step's slot.
- notes_out  output  NOTE_W  note vector to the sound stage.
- playing  output  1  high in SOUND or GAP.
- step_done  output  1  one-cycle pulse at the end of each step's gap.
- seq_done  output  1  one-cycle pulse when a non-looping sequence completes.

Behaviour:
- One clock, CLOCK_50. Reset is synchronous and active-high. All state updates occur on the posedge of CLOCK_50.
- Reset forces: state=IDLE, slot_sel=0, tick counter=0, latched length=0, step_done=0, seq_done=0, notes_out=0, playing=0. Reset has priority over every other input.
- States are IDLE, SOUND and GAP.
- notes_out = slot_notes slice [slot_sel] while state==SOUND, else 0. It is combinational from registered state, so it reflects live slot contents; chord rewrites during SOUND appear next cycle.
- playing = (state != IDLE).
- IDLE:
  - start=1 and stop=0 at an edge: latch num_steps, slot_sel<=0, counter<=0, go to SOUND.
  - Notes become valid in the cycle following that edge.
- SOUND:
  - Counter increments each cycle.
  - When counter==TICKS_PER_STEP-1: counter<=0. If GAP_TICKS>0, go to GAP; otherwise perform the step-end action below on the same edge.
  - The sound window is exactly TICKS_PER_STEP cycles.
- GAP:
  - Counter increments each cycle.
  - When counter==GAP_TICKS-1: perform the step-end action.
  - The gap is exactly GAP_TICKS cycles with notes_out=0.
- Step-end action:
  - step_done=1 for that one cycle, registered so it is visible in the cycle after the edge.
  - If slot_sel < latched length: slot_sel+1, go to SOUND.
  - Otherwise, if loop_en=1 (sampled at this edge): slot_sel<=0, go to SOUND.
  - Otherwise: go to IDLE and pulse seq_done together with step_done.
- stop=1 in SOUND or GAP:
  - Go to IDLE on that edge, slot_sel<=0, counter<=0.
  - No step_done or seq_done pulse; notes_out=0 next cycle.
- start=1 while in SOUND or GAP is ignored; it does not restart the sequence.
- start and stop both high in IDLE: stop wins and the block stays IDLE.
- Changing num_steps mid-sequence has no effect until the next accepted start.
- Clearing loop_en mid-pass ends the sequence after the current last step.
- Reset mid-sequence returns to IDLE next cycle with all outputs at reset values and no pulses.
- Minimum step period is TICKS_PER_STEP+GAP_TICKS cycles.
- One-step length (num_steps=0) with loop_en=1 repeats slot 0 indefinitely.

Test Plan:
- Bench params for all scenarios: TICKS_PER_STEP=4, GAP_TICKS=2. Slot contents: slot0=10'h001, slot1=10'h002, slot2=10'h004, slot3=10'h3FF.
- Basic run: num_steps=3, loop_en=0, start pulse.
  - Required: notes_out = 001×4, 0×2, 002×4, 0×2, 004×4, 0×2, 3FF×4, 0×2.
  - step_done pulses 4 times, at 6-cycle spacing.
  - seq_done coincides with the 4th step_done; playing falls the same cycle.
- Loop: num_steps=1, loop_en=1, run 30 cycles.
  - Required: slot_sel sequence 0,1,0,1,0; seq_done never asserts.
  - Then clear loop_en: the sequence ends after the next slot-1 step, with one seq_done.
- Abort: stop asserted in the 2nd SOUND cycle of slot 2.
  - Required: state IDLE, notes_out=0 and slot_sel=0 next cycle; no step_done or seq_done.
  - start=stop=1 in IDLE: playing stays 0.
- Ignored restart and latched length: start held high through playback; num_steps changed from 0 to 3 mid-step.
  - Required: only slot 0 plays once, then seq_done; a fresh start afterwards plays 4 steps.
- Zero gap and live update, with GAP_TICKS=0:
  - Required: notes_out 001×4 then 002×4 back-to-back, with no zero cycle.
  - Rewriting slot1 to 10'h155 mid-window shows 155 on notes_out the next cycle.
- Reset mid-GAP: all outputs return to reset values next cycle; a subsequent start begins at slot 0.
